// File: rtl/shiftreg_seq.sv
// Symbol shift register feeding the code emitter. It holds REGS slots of BITS bits,
// and each command shifts the register left by shamt bits, at most STEP bits per cycle.
// Latency: ceil(shamt/STEP) BUSY cycles after accept, then a done pulse (shamt=0: done next cycle).
// Backpressure: cmd_ready is high only in IDLE. load and cmd_valid are ignored while BUSY.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   cmd_valid/cmd_ready command handshake; shamt and mode are sampled on accept
//   load, load_data     IDLE-only register load; load takes priority over a command
//   out                 top slot captured on accept
//   done, err           completion pulse; err marks a zero-fill shift that underflowed fill
//   fill, empty         count of valid bits, and fill==0
module shiftreg_seq #(
  parameter int REGS   = 8,
  parameter int BITS   = 3,
  parameter int SHIFTS = 10,
  parameter int STEP   = 3,
  parameter int FW     = $clog2(REGS*BITS+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [SHIFTS-1:0]      shamt,
  input  logic                   mode,
  input  logic                   load,
  input  logic [REGS*BITS-1:0]   load_data,
  output logic [BITS-1:0]        out,
  output logic                   done,
  output logic                   err,
  output logic [FW-1:0]          fill,
  output logic                   empty
);

  localparam int W  = REGS * BITS;
  localparam int CW = (SHIFTS > FW) ? SHIFTS : FW;
  localparam logic [SHIFTS-1:0] STEP_S = SHIFTS'(STEP);

  // Slot i holds REGS-1-i, so the first symbol extracted is 0.
  function automatic logic [W-1:0] reset_image();
    logic [W-1:0] img;
    img = '0;
    for (int i = 0; i < REGS; i++) begin
      img[BITS*i +: BITS] = BITS'(REGS - 1 - i);
    end
    return img;
  endfunction

  localparam logic [W-1:0] RST_IMG = reset_image();

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q;
  logic [W-1:0]       data_q;
  logic [BITS-1:0]    out_q;
  logic [FW-1:0]      fill_q;
  logic [SHIFTS-1:0]  rem_q;
  logic               mode_q;
  logic               err_pend_q;
  logic               done_q;
  logic               err_q;

  // Per-cycle shift step and the shifted register image.
  logic [SHIFTS-1:0]  step_d;
  logic [SHIFTS-1:0]  rem_d;
  logic [2*W-1:0]     dbl_d;
  logic [W-1:0]       shift_d;
  // Fill accounting for a zero-fill accept, compared at a common width.
  logic [CW-1:0]      shamt_w;
  logic [CW-1:0]      fill_w;
  logic               under_d;
  logic [FW-1:0]      fill_d;

  always_comb begin
    step_d  = (rem_q < STEP_S) ? rem_q : STEP_S;
    rem_d   = rem_q - step_d;
    // Shifting the doubled word moves the top bits into the low half, which gives the rotate.
    dbl_d   = {data_q, data_q} << step_d;
    shift_d = mode_q ? dbl_d[2*W-1:W] : (data_q << step_d);
    shamt_w = CW'(shamt);
    fill_w  = CW'(fill_q);
    under_d = shamt_w > fill_w;
    // shamt == fill empties the register exactly and is not an underflow.
    fill_d  = (shamt_w >= fill_w) ? '0 : FW'(fill_w - shamt_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= RST_IMG;
      out_q      <= '0;
      fill_q     <= FW'(W);
      rem_q      <= '0;
      mode_q     <= 1'b0;
      err_pend_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            data_q <= load_data;
            fill_q <= FW'(W);
          end else if (cmd_valid) begin
            out_q      <= data_q[W-1 -: BITS];
            rem_q      <= shamt;
            mode_q     <= mode;
            err_pend_q <= ~mode & under_d;
            if (!mode) begin
              fill_q <= fill_d;
            end
            if (shamt == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          data_q <= shift_d;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            err_q   <= err_pend_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign out       = out_q;
  assign done      = done_q;
  assign err       = err_q;
  assign fill      = fill_q;
  assign empty     = (fill_q == '0);

endmodule

// File: doc/shiftreg_seq.md
# shiftreg_seq

Clocked, parametrised successor to the Huffman symbol shift register. It holds REGS slots of BITS bits each and presents the top slot as the output symbol. On a handshaked command it shifts the whole register left by a variable bit count over one or more cycles, in zero-fill or rotate mode. It sits between the Huffman tree builder (symbol ordering) and the code emitter, and adds load, fill tracking, underflow error and a done pulse.

## Interface
- REGS, 8, number of slots
- BITS, 3, bits per slot
- SHIFTS, 10, width of shamt
- STEP, 3, maximum bits shifted per BUSY cycle (1..REGS*BITS)
- FW, clog2(REGS*BITS+1), width of fill
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  shift command request
- cmd_ready  out  1  command accept; high only in IDLE
- shamt  in  SHIFTS  shift amount in bits, sampled on accept
- mode  in  1  0 = shift left with zero fill, 1 = rotate left; sampled on accept
- load  in  1  load register from load_data; honoured only in IDLE
- load_data  in  REGS*BITS  new register contents
- out  out  BITS  top slot captured on accept
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse, coincident with done, on underflow
- fill  out  FW  count of valid (non-filler) bits
- empty  out  1  fill == 0, combinational from fill

## Operation
- Slot i occupies bits [BITS*i +: BITS]. The top slot is i = REGS-1.
- Reset image: slot i = REGS-1-i, so the top slot holds 0. Also on reset: out=0, fill=REGS*BITS, done=0, err=0, state IDLE, cmd_ready=1.
- States are IDLE and BUSY. cmd_ready = (state==IDLE).
- Load in IDLE:
  - load=1 loads load_data and sets fill=REGS*BITS.
  - load has priority over cmd_valid in the same cycle. The command is not accepted and cmd_ready stays high.
- Accept (IDLE, cmd_valid=1, load=0):
  - out <= top slot before any shift.
  - rem <= shamt; mode is latched.
  - Mode 0: fill <= max(fill - shamt, 0). If shamt > fill, the pending err flag is set.
  - Mode 1: fill is unchanged.
  - If shamt==0: stay in IDLE and pulse done on the next cycle; the register is unchanged.
  - Otherwise go to BUSY.
- Each BUSY cycle:
  - s = min(rem, STEP).
  - Shift the register left by s bits. Mode 0 fills with zeros; mode 1 wraps the top bits into the bottom.
  - rem <= rem - s.
  - When rem - s == 0: go to IDLE, pulse done, and pulse err if it is pending.
- Large shifts:
  - shamt >= REGS*BITS in mode 0 leaves the register all zeros, fill=0 and err=1.
  - In mode 1 the result equals rotation by shamt mod (REGS*BITS).
- Ignored inputs: load, cmd_valid, shamt and mode are ignored in BUSY. shamt and mode need not be held after accept.
- rst in any state, including mid-BUSY, restores the reset image within one edge. Any pending done or err is discarded.

## Timing
- Command accepted at edge 0. For k = ceil(shamt/STEP), the BUSY edges are 1..k.
- done, err and cmd_ready=1 are all visible in the cycle after edge k.
- For shamt=0: done is high in the cycle after edge 0, and cmd_ready stays high throughout.
- out updates in the cycle after edge 0 and holds until the next accept.
- fill updates in the cycle after edge 0.
- A new command can be accepted in the same cycle done is high, giving one command per k+1 cycles.
- A load takes effect in the cycle after its edge. An accept in that next cycle sees the loaded top slot.

## Test plan
- Reset, then shamt=3, mode=0, no prior load:
  - out=0, done is high 2 cycles after the accept cycle.
  - fill=21, the new top slot is 1.
- Sequential extraction: issue shamt=3 eight times.
  - out sequence is 0,1,2,3,4,5,6,7.
  - fill ends at 0, empty=1, err never set.
- shamt=7, mode=1 on the reset image:
  - 3 BUSY cycles; done is high in the cycle after the 3rd BUSY edge.
  - Register equals the reset image rotated left by 7; fill=24.
- Underflow: shamt=30, mode=0 with fill=24.
  - Register is all zeros, fill=0.
  - err and done are high together after 10 BUSY cycles.
- load=1 and cmd_valid=1 in the same IDLE cycle with load_data=24'hFFFFFF:
  - The load wins and the command is not accepted.
  - The next accept returns out=3'b111.
- Edge cases:
  - rst asserted in the 2nd BUSY cycle of shamt=9: the reset image is restored next cycle and no done pulse occurs.
  - shamt=0: done after 1 cycle, register unchanged.
